// File: rtl/wisc_isa_pkg.sv
// Shared WISC-SP20 definitions: opcodes, immediate-format selects and
// decode-stage FSM states.
package wisc_isa_pkg;

    // 5-bit major opcodes (inst[15:11])
    localparam logic [4:0] OP_HALT  = 5'b00000;
    localparam logic [4:0] OP_J     = 5'b00100;
    localparam logic [4:0] OP_JR    = 5'b00101;
    localparam logic [4:0] OP_JAL   = 5'b00110;
    localparam logic [4:0] OP_JALR  = 5'b00111;
    localparam logic [4:0] OP_ADDI  = 5'b01000;
    localparam logic [4:0] OP_SUBI  = 5'b01001;
    localparam logic [4:0] OP_XORI  = 5'b01010;
    localparam logic [4:0] OP_ANDNI = 5'b01011;
    localparam logic [4:0] OP_BEQZ  = 5'b01100;
    localparam logic [4:0] OP_BNEZ  = 5'b01101;
    localparam logic [4:0] OP_BLTZ  = 5'b01110;
    localparam logic [4:0] OP_BGEZ  = 5'b01111;
    localparam logic [4:0] OP_ST    = 5'b10000;
    localparam logic [4:0] OP_LD    = 5'b10001;
    localparam logic [4:0] OP_SLBI  = 5'b10010;
    localparam logic [4:0] OP_STU   = 5'b10011;
    localparam logic [4:0] OP_ROLI  = 5'b10100;
    localparam logic [4:0] OP_SLLI  = 5'b10101;
    localparam logic [4:0] OP_RORI  = 5'b10110;
    localparam logic [4:0] OP_SRLI  = 5'b10111;
    localparam logic [4:0] OP_LBI   = 5'b11000;

    // Immediate field width selects for the extender
    localparam logic [1:0] EXT_SM  = 2'b00;  // inst[4:0]
    localparam logic [1:0] EXT_LG  = 2'b01;  // inst[7:0]
    localparam logic [1:0] EXT_DIS = 2'b10;  // inst[10:0]

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } id_state_t;

endpackage

// File: rtl/extend.sv
// Immediate extender: selects a 5/8/11-bit field and sign- or zero-extends
// it to N bits. Pure bit selection, no arithmetic.
module extend
    import wisc_isa_pkg::*;
#(
    parameter int unsigned N = 16
) (
    input  logic [10:0]  field,
    input  logic         sign,
    input  logic [1:0]   ext_op,
    output logic [N-1:0] imm
);

    always_comb begin
        imm = '0;
        case (ext_op)
            EXT_SM:  imm = {{(N-5){sign & field[4]}}, field[4:0]};
            EXT_LG:  imm = {{(N-8){sign & field[7]}}, field[7:0]};
            EXT_DIS: imm = {{(N-11){sign & field[10]}}, field[10:0]};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/imm_class.sv
// Opcode classifier: picks immediate width and signedness for the extender
// and flags whether the instruction carries an immediate at all.
module imm_class
    import wisc_isa_pkg::*;
(
    input  logic [4:0] opcode,
    output logic       ext_sign,
    output logic [1:0] ext_op,
    output logic       use_imm
);

    always_comb begin
        ext_sign = 1'b0;
        ext_op   = EXT_SM;
        use_imm  = 1'b1;
        unique case (opcode)
            OP_ADDI, OP_SUBI, OP_ST, OP_LD, OP_STU: begin
                ext_sign = 1'b1;
            end
            OP_XORI, OP_ANDNI, OP_ROLI, OP_SLLI, OP_RORI, OP_SRLI: begin
                ext_sign = 1'b0;
            end
            OP_BEQZ, OP_BNEZ, OP_BLTZ, OP_BGEZ, OP_LBI, OP_JR, OP_JALR: begin
                ext_op   = EXT_LG;
                ext_sign = 1'b1;
            end
            OP_SLBI: begin
                ext_op = EXT_LG;
            end
            OP_J, OP_JAL: begin
                ext_op   = EXT_DIS;
                ext_sign = 1'b1;
            end
            default: begin
                use_imm = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/id_stage_ctrl.sv
// Decode-stage sequencer: accepts fetched instructions, extends the immediate
// and holds the result at the ID/EX boundary, with flush and HALT handling.
module id_stage_ctrl
    import wisc_isa_pkg::*;
#(
    parameter int unsigned N       = 16,
    parameter logic [4:0]  HALT_OP = OP_HALT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         if_valid,
    input  logic [N-1:0] if_inst,
    input  logic [N-1:0] if_pc,
    output logic         if_ready,
    input  logic         flush,
    input  logic         ex_ready,
    output logic         id_valid,
    output logic [N-1:0] id_inst,
    output logic [N-1:0] id_pc,
    output logic [N-1:0] id_imm,
    output logic         id_use_imm,
    output logic         id_halt,
    output logic         halted
);

    id_state_t    state;
    logic [4:0]   opcode;
    logic         ext_sign;
    logic [1:0]   ext_op;
    logic         use_imm;
    logic [N-1:0] imm;
    logic         accept;
    logic         is_halt;

    assign opcode = if_inst[N-1 -: 5];

    imm_class u_imm_class (
        .opcode   (opcode),
        .ext_sign (ext_sign),
        .ext_op   (ext_op),
        .use_imm  (use_imm)
    );

    extend #(
        .N (N)
    ) u_extend (
        .field  (if_inst[10:0]),
        .sign   (ext_sign),
        .ext_op (ext_op),
        .imm    (imm)
    );

    // Ready only looks at our own occupancy, never at if_valid.
    assign if_ready = (state == ST_RUN) & ~flush & (~id_valid | ex_ready);
    assign accept   = if_valid & if_ready;
    assign is_halt  = (opcode == HALT_OP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_RUN;
            halted     <= 1'b0;
            id_valid   <= 1'b0;
            id_inst    <= '0;
            id_pc      <= '0;
            id_imm     <= '0;
            id_use_imm <= 1'b0;
            id_halt    <= 1'b0;
        end else if (flush) begin
            // Redirect kills the held instruction and any wrong-path HALT.
            id_valid <= 1'b0;
            id_halt  <= 1'b0;
            state    <= ST_RUN;
            halted   <= 1'b0;
        end else if (accept) begin
            id_valid   <= 1'b1;
            id_inst    <= if_inst;
            id_pc      <= if_pc;
            id_imm     <= imm;
            id_use_imm <= use_imm;
            id_halt    <= is_halt;
            if (is_halt) begin
                state  <= ST_HALTED;
                halted <= 1'b1;
            end
        end else if (ex_ready && id_valid) begin
            id_valid <= 1'b0;
            id_halt  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_id_stage_ctrl.sv
// Directed bench for id_stage_ctrl: scoreboard of expected ID/EX contents
// pushed at issue time and popped one cycle later when the stage presents them.
module tb_id_stage_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_valid;
    logic [15:0] if_inst;
    logic [15:0] if_pc;
    logic        if_ready;
    logic        flush;
    logic        ex_ready;
    logic        id_valid;
    logic [15:0] id_inst;
    logic [15:0] id_pc;
    logic [15:0] id_imm;
    logic        id_use_imm;
    logic        id_halt;
    logic        halted;

    typedef struct packed {
        logic [15:0] inst;
        logic [15:0] pc;
        logic [15:0] imm;
        logic        use_imm;
        logic        halt;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    id_stage_ctrl #(
        .N       (16),
        .HALT_OP (5'b00000)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .if_valid   (if_valid),
        .if_inst    (if_inst),
        .if_pc      (if_pc),
        .if_ready   (if_ready),
        .flush      (flush),
        .ex_ready   (ex_ready),
        .id_valid   (id_valid),
        .id_inst    (id_inst),
        .id_pc      (id_pc),
        .id_imm     (id_imm),
        .id_use_imm (id_use_imm),
        .id_halt    (id_halt),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction with ex_ready=1, expect it accepted, then
    // compare the popped expectation against the registered outputs.
    task automatic issue(input logic [15:0] inst, input logic [15:0] pc,
                         input logic [15:0] imm, input logic use_imm, input logic halt);
        exp_t e;
        if_valid = 1'b1;
        if_inst  = inst;
        if_pc    = pc;
        ex_ready = 1'b1;
        flush    = 1'b0;
        #1;
        check("issue_if_ready", {15'd0, if_ready}, 16'd1);
        sb.push_back('{inst: inst, pc: pc, imm: imm, use_imm: use_imm, halt: halt});
        tick();
        if_valid = 1'b0;
        if (sb.size() == 0) begin
            check("sb_underflow", 16'd1, 16'd0);
        end else begin
            e = sb.pop_front();
            check("id_valid", {15'd0, id_valid}, 16'd1);
            check("id_inst", id_inst, e.inst);
            check("id_pc", id_pc, e.pc);
            check("id_imm", id_imm, e.imm);
            check("id_use_imm", {15'd0, id_use_imm}, {15'd0, e.use_imm});
            check("id_halt", {15'd0, id_halt}, {15'd0, e.halt});
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        if_valid = 1'b0;
        if_inst  = '0;
        if_pc    = '0;
        flush    = 1'b0;
        ex_ready = 1'b0;
        #12;
        check("rst_id_valid", {15'd0, id_valid}, 16'd0);
        check("rst_id_inst", id_inst, 16'h0000);
        check("rst_id_imm", id_imm, 16'h0000);
        check("rst_halted", {15'd0, halted}, 16'd0);
        check("rst_id_halt", {15'd0, id_halt}, 16'd0);
        check("rst_if_ready", {15'd0, if_ready}, 16'd1);
        #10;
        rst_n = 1'b1;
        tick();

        // Immediate formats
        issue(16'h423F, 16'h0002, 16'hFFFF, 1'b1, 1'b0);  // ADDI
        issue(16'h523F, 16'h0004, 16'h001F, 1'b1, 1'b0);  // XORI
        issue(16'hC180, 16'h0006, 16'hFF80, 1'b1, 1'b0);  // LBI
        issue(16'h9180, 16'h0008, 16'h0080, 1'b1, 1'b0);  // SLBI
        issue(16'h2400, 16'h000A, 16'hFC00, 1'b1, 1'b0);  // J
        issue(16'hD8E5, 16'h000C, 16'h0005, 1'b0, 1'b0);  // no-immediate opcode

        // Consume without accept keeps payload
        ex_ready = 1'b1;
        tick();
        check("consume_id_valid", {15'd0, id_valid}, 16'd0);
        check("consume_id_inst", id_inst, 16'hD8E5);

        // Back-pressure
        issue(16'h423F, 16'h0010, 16'hFFFF, 1'b1, 1'b0);
        ex_ready = 1'b0;
        if_valid = 1'b1;
        if_inst  = 16'h523F;
        if_pc    = 16'h0012;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_if_ready", {15'd0, if_ready}, 16'd0);
            tick();
            check("bp_id_valid", {15'd0, id_valid}, 16'd1);
            check("bp_id_inst", id_inst, 16'h423F);
            check("bp_id_imm", id_imm, 16'hFFFF);
            check("bp_id_pc", id_pc, 16'h0010);
        end
        issue(16'h523F, 16'h0012, 16'h001F, 1'b1, 1'b0);
        tick();
        check("bp_drain", {15'd0, id_valid}, 16'd0);

        // HALT entry, then drain while parked
        issue(16'h0000, 16'h0020, 16'h0000, 1'b0, 1'b1);
        check("halt_halted", {15'd0, halted}, 16'd1);
        ex_ready = 1'b0;
        if_valid = 1'b1;
        if_inst  = 16'h423F;
        #1;
        check("halt_if_ready_held", {15'd0, if_ready}, 16'd0);
        ex_ready = 1'b1;
        #1;
        check("halt_if_ready_ex", {15'd0, if_ready}, 16'd0);
        tick();
        check("halt_consumed", {15'd0, id_valid}, 16'd0);
        check("halt_stays", {15'd0, halted}, 16'd1);
        check("halt_no_accept", id_inst, 16'h0000);

        // Flush in HALTED leaves via RUN
        flush    = 1'b1;
        if_valid = 1'b0;
        tick();
        flush = 1'b0;
        check("flush_halted_exit", {15'd0, halted}, 16'd0);
        check("flush_id_valid", {15'd0, id_valid}, 16'd0);
        #1;
        check("flush_if_ready_after", {15'd0, if_ready}, 16'd1);

        // Wrong-path HALT held, flush and ex_ready together
        issue(16'h0000, 16'h0030, 16'h0000, 1'b0, 1'b1);
        flush    = 1'b1;
        ex_ready = 1'b1;
        if_valid = 1'b1;
        if_inst  = 16'h523F;
        #1;
        check("flush_if_ready", {15'd0, if_ready}, 16'd0);
        tick();
        flush    = 1'b0;
        if_valid = 1'b0;
        check("flush_ex_id_valid", {15'd0, id_valid}, 16'd0);
        check("flush_ex_halted", {15'd0, halted}, 16'd0);
        check("flush_ex_id_halt", {15'd0, id_halt}, 16'd0);
        #1;
        check("flush_ex_if_ready", {15'd0, if_ready}, 16'd1);

        // Flush in RUN blocks the accept in that cycle
        issue(16'h423F, 16'h0040, 16'hFFFF, 1'b1, 1'b0);
        flush    = 1'b1;
        if_valid = 1'b1;
        if_inst  = 16'h523F;
        tick();
        flush    = 1'b0;
        if_valid = 1'b0;
        check("flush_run_id_valid", {15'd0, id_valid}, 16'd0);
        check("flush_run_id_inst", id_inst, 16'h423F);

        // Async reset mid-cycle while a HALT with nonzero imm is held
        issue(16'h001F, 16'h0050, 16'h001F, 1'b0, 1'b1);
        ex_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_id_valid", {15'd0, id_valid}, 16'd0);
        check("arst_id_imm", id_imm, 16'h0000);
        check("arst_halted", {15'd0, halted}, 16'd0);
        check("arst_id_inst", id_inst, 16'h0000);
        #10;
        rst_n = 1'b1;
        tick();
        issue(16'h523F, 16'h0060, 16'h001F, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
